// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes, FSM states
// and operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic fn_signed_a(input logic [2:0] fn);
    return (fn == FN_MUL) || (fn == FN_MULH) || (fn == FN_MULHSU) ||
           (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic fn_signed_b(input logic [2:0] fn);
    return (fn == FN_MUL) || (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative radix-2 shift-add multiplier / restoring divider sharing one
// accumulator pair, with operand magnitude conversion and result sign fixup.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [2:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_special,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_func;
  logic             r_neg;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_result;

  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_b_zero, w_ovf;
  logic [WIDTH-1:0] w_special_res;

  assign w_sa    = fn_signed_a(i_func) & i_a[WIDTH-1];
  assign w_sb    = fn_signed_b(i_func) & i_b[WIDTH-1];
  assign w_a_mag = w_sa ? (~i_a + 1'b1) : i_a;
  assign w_b_mag = w_sb ? (~i_b + 1'b1) : i_b;

  assign w_b_zero  = (i_b == '0);
  assign w_ovf     = ((i_func == FN_DIV) || (i_func == FN_REM)) &&
                     (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
  assign o_special = i_func[2] && (w_b_zero || w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero)
      w_special_res = i_func[1] ? i_a : '1;
    else if (w_ovf)
      w_special_res = i_func[1] ? '0 : i_a;
  end

  // One iteration: multiply adds the multiplicand then shifts {hi,lo} right;
  // divide shifts the dividend into the partial remainder and trial-subtracts.
  logic [WIDTH:0]   w_sum, w_shifted, w_trial;
  logic [WIDTH:0]   w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  assign w_sum     = {1'b0, r_hi[WIDTH-1:0]} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shifted = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_b};

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (!r_func[2]) begin
      w_hi_n = {1'b0, w_sum[WIDTH:1]};
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_hi_n = w_trial;
      w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_n = w_shifted;
      w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_final;

  assign w_prod   = {w_hi_n[WIDTH-1:0], w_lo_n};
  assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_neg ? (~w_lo_n + 1'b1) : w_lo_n;
  assign w_rem    = r_neg_r ? (~w_hi_n[WIDTH-1:0] + 1'b1) : w_hi_n[WIDTH-1:0];

  always_comb begin
    w_final = '0;
    if (r_func[2])
      w_final = r_func[1] ? w_rem : w_quo;
    else if (r_func == FN_MUL)
      w_final = w_prod_s[WIDTH-1:0];
    else
      w_final = w_prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_func   <= '0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (i_start) begin
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_b     <= w_b_mag;
      r_func  <= i_func;
      r_neg   <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      if (o_special)
        r_result <= w_special_res;
    end else if (i_step) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (i_cnt == CNT_W'(1))
        r_result <= w_final;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: IDLE/CALC/DONE control FSM with valid/ready
// handshakes and flush, around the iterative datapath.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_accept, w_step, w_special;

  // Flush in IDLE blocks acceptance so a killed slot never starts work.
  assign w_accept = (r_state == ST_IDLE) && inValid && !flush;
  assign w_step   = (r_state == ST_CALC) && !flush;

  muldiv_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept),
    .i_step    (w_step),
    .i_cnt     (r_cnt),
    .i_func    (func3),
    .i_a       (dataA),
    .i_b       (dataB),
    .o_special (w_special),
    .o_result  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_CALC;
              r_cnt   <= CNT_W'(WIDTH);
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_DONE;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (flush || outReady) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency,
// backpressure, flush and asynchronous reset behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [2:0]  func3;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .func3    (func3),
    .dataA    (dataA),
    .dataB    (dataB),
    .flush    (flush),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int hold,
                        input string tag);
    int          n;
    logic        ir_bad;
    logic        st_bad;
    logic [31:0] held;
    check({tag, ".inReady_pre"}, 32'(inReady), 32'd1);
    func3    = f;
    dataA    = a;
    dataB    = b;
    inValid  = 1'b1;
    outReady = (hold == 0);
    @(posedge clk); #1;
    inValid = 1'b0;
    dataA   = 32'hDEAD_BEEF;
    dataB   = 32'h0BAD_F00D;
    n       = 1;
    ir_bad  = 1'b0;
    if (inReady) ir_bad = 1'b1;
    while (!outValid && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (inReady) ir_bad = 1'b1;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".result"}, result, exp);
    check({tag, ".inReady_busy"}, 32'(ir_bad), 32'd0);
    if (hold > 0) begin
      held   = result;
      st_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (result !== held || inReady !== 1'b0 || outValid !== 1'b1) st_bad = 1'b1;
      end
      check({tag, ".hold_stable"}, 32'(st_bad), 32'd0);
      outReady = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".outValid_post"}, 32'(outValid), 32'd0);
    check({tag, ".inReady_post"}, 32'(inReady), 32'd1);
    outReady = 1'b0;
    $display("op %s func3=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, f, a, b, exp, n);
  endtask

  initial begin
    logic ov_seen;
    rst_n = 1'b0; inValid = 1'b0; func3 = '0; dataA = '0; dataB = '0;
    flush = 1'b0; outReady = 1'b0;
    #12;
    check("rst.inReady", 32'(inReady), 32'd1);
    check("rst.outValid", 32'(outValid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(FN_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "MUL");
    run_op(FN_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0, "MULH");
    run_op(FN_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "MULHU");
    run_op(FN_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 33, 0, "MULHSU");
    run_op(FN_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 33, 0, "DIV");
    run_op(FN_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33, 0, "REM");
    run_op(FN_DIVU,   32'd100,        32'd7,         32'd14,        33, 0, "DIVU");
    run_op(FN_REMU,   32'd100,        32'd7,         32'd2,         33, 0, "REMU");
    run_op(FN_DIV,    32'd55,         32'd0,         32'hFFFF_FFFF, 1,  0, "DIV_by0");
    run_op(FN_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1,  0, "REMU_by0");
    run_op(FN_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, "DIV_ovf");
    run_op(FN_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  0, "REM_ovf");
    run_op(FN_DIVU,   32'd100,        32'd7,         32'd14,        33, 10, "DIVU_bp");

    // Flush during the fifth CALC iteration.
    func3 = FN_MUL; dataA = 32'd5; dataB = 32'd5; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (outValid) ov_seen = 1'b1;
    end
    check("flush.busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (outValid) ov_seen = 1'b1;
    check("flush.inReady", 32'(inReady), 32'd1);
    check("flush.busy", 32'(busy), 32'd0);
    check("flush.outValid_seen", 32'(ov_seen), 32'd0);
    $display("op flush_calc iteration=5 inReady=%0d busy=%0d", inReady, busy);

    // Flush in IDLE suppresses a simultaneous request.
    flush = 1'b1; inValid = 1'b1; func3 = FN_MUL; dataA = 32'd2; dataB = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    check("flush_idle.inReady", 32'(inReady), 32'd1);
    check("flush_idle.busy", 32'(busy), 32'd0);
    $display("op flush_idle inReady=%0d busy=%0d", inReady, busy);

    // Asynchronous reset in the middle of a divide.
    func3 = FN_DIVU; dataA = 32'd1000; dataB = 32'd3; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (outValid) ov_seen = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst.inReady", 32'(inReady), 32'd1);
    check("arst.outValid", 32'(outValid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.result", result, 32'd0);
    check("arst.outValid_seen", 32'(ov_seen), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("op async_reset_mid_calc inReady=%0d busy=%0d", inReady, busy);

    run_op(FN_MUL, 32'd3, 32'd4, 32'd12, 33, 0, "MUL_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
